// File: rtl/minifloat_pkg.sv
// Shared minifloat format definitions: field widths, bias, special encodings,
// converter FSM states and flag bit positions.
package minifloat_pkg;

    localparam int EXP_W      = 4;
    localparam int MANTISSA_W = 3;
    localparam int WIDTH      = 1 + EXP_W + MANTISSA_W;
    localparam int BIAS       = (1 << (EXP_W - 1)) - 1;

    typedef struct packed {
        logic                  sign;
        logic [EXP_W-1:0]      exp;
        logic [MANTISSA_W-1:0] mant;
    } minifloat_t;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam minifloat_t INF_POS = '{sign: 1'b0, exp: EXP_MAX, mant: '0};
    localparam minifloat_t INF_NEG = '{sign: 1'b1, exp: EXP_MAX, mant: '0};

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam int FLAG_INX = 0;
    localparam int FLAG_OVF = 1;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/int_to_minifloat_if.sv
// Operand-in / minifloat-out handshake bundle between producer, converter and ALU.
interface int_to_minifloat_if #(
    parameter int INT_W = 8,
    parameter int WIDTH = 8
);
    logic signed [INT_W-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        result;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              flags;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, result, out_valid, flags
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, result, out_valid, flags
    );
endinterface

// File: rtl/minifloat_round.sv
// Combinational round-to-nearest-even packer: normalised magnitude, leading-zero
// count and sign in, minifloat word and {overflow, inexact} out.
module minifloat_round #(
    parameter int INT_W      = 8,
    parameter int EXP_W      = minifloat_pkg::EXP_W,
    parameter int MANTISSA_W = minifloat_pkg::MANTISSA_W,
    parameter int LZ_W       = $clog2(INT_W + 1),
    parameter int WIDTH      = 1 + EXP_W + MANTISSA_W
) (
    input  logic [INT_W-1:0] mag,
    input  logic [LZ_W-1:0]  lz,
    input  logic             sign,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags
);
    import minifloat_pkg::*;

    // Zero padding below the magnitude keeps guard/sticky defined for any INT_W.
    localparam int XW   = INT_W + MANTISSA_W + 1;
    localparam int EBW  = EXP_W + 2;
    localparam int BIAS = bias_of(EXP_W);

    logic [XW-1:0]         ext;
    logic [MANTISSA_W-1:0] mant;
    logic                  guard;
    logic                  sticky;
    logic [MANTISSA_W:0]   rounded;
    logic [EBW-1:0]        eb;

    function automatic logic [MANTISSA_W:0] rne(
        input logic [MANTISSA_W-1:0] m,
        input logic                  g,
        input logic                  s
    );
        logic up;
        up = g & (s | m[0]);
        return {1'b0, m} + {{MANTISSA_W{1'b0}}, up};
    endfunction

    always_comb begin
        ext     = {mag[INT_W-2:0], {(MANTISSA_W + 2){1'b0}}};
        mant    = ext[XW-1 -: MANTISSA_W];
        guard   = ext[XW-1-MANTISSA_W];
        sticky  = |ext[XW-2-MANTISSA_W:0];
        rounded = rne(mant, guard, sticky);
        eb      = EBW'(INT_W - 1 + BIAS) - EBW'(lz) + EBW'(rounded[MANTISSA_W]);
        result  = '0;
        flags   = '0;
        // A normalised non-zero magnitude always has its MSB set.
        if (mag[INT_W-1]) begin
            flags[FLAG_INX] = guard | sticky;
            if (eb >= EBW'((1 << EXP_W) - 1)) begin
                flags[FLAG_OVF] = 1'b1;
                result          = {sign, {EXP_W{1'b1}}, {MANTISSA_W{1'b0}}};
            end else begin
                result = {sign, eb[EXP_W-1:0], rounded[MANTISSA_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/int_to_minifloat.sv
// Serial signed-integer to minifloat converter: one normalise shift per cycle,
// then a single RNE rounding cycle, result held until the consumer takes it.
module int_to_minifloat #(
    parameter int INT_W      = 8,
    parameter int EXP_W      = minifloat_pkg::EXP_W,
    parameter int MANTISSA_W = minifloat_pkg::MANTISSA_W,
    parameter int WIDTH      = 1 + EXP_W + MANTISSA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    int_to_minifloat_if.slave   bus
);
    import minifloat_pkg::*;

    localparam int LZ_W = $clog2(INT_W + 1);

    state_t           state;
    logic             sign;
    logic [INT_W-1:0] mag;
    logic [LZ_W-1:0]  lz;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [1:0]       flags_r;
    logic [WIDTH-1:0] rnd_result;
    logic [1:0]       rnd_flags;
    logic             accept;
    logic             norm_shift;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign norm_shift = (state == NORM) && (mag != '0) && !mag[INT_W-1];

    // Operand registers carry no reset; the FSM decides when they are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign <= bus.in_data[INT_W-1];
            mag  <= bus.in_data[INT_W-1] ? INT_W'(-bus.in_data) : INT_W'(bus.in_data);
            lz   <= '0;
        end else if (norm_shift) begin
            mag <= mag << 1;
            lz  <= lz + LZ_W'(1);
        end
    end

    minifloat_round #(
        .INT_W      (INT_W),
        .EXP_W      (EXP_W),
        .MANTISSA_W (MANTISSA_W),
        .LZ_W       (LZ_W),
        .WIDTH      (WIDTH)
    ) u_round (
        .mag    (mag),
        .lz     (lz),
        .sign   (sign),
        .result (rnd_result),
        .flags  (rnd_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            flags_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state      <= NORM;
                        in_ready_r <= 1'b0;
                    end
                end
                NORM: begin
                    if (!norm_shift) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result_r    <= rnd_result;
                    flags_r     <= rnd_flags;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.flags     = flags_r;

endmodule

// File: tb/tb_int_to_minifloat.sv
// Directed bench for int_to_minifloat: 8-bit and 16-bit builds, vector tables
// plus backpressure and mid-conversion reset sequences.
module tb_int_to_minifloat;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    int_to_minifloat_if #(.INT_W(8),  .WIDTH(8)) i8 ();
    int_to_minifloat_if #(.INT_W(16), .WIDTH(8)) i16 ();

    int_to_minifloat #(.INT_W(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i8)
    );

    int_to_minifloat #(.INT_W(16)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] res;
        logic [1:0] flg;
        int         lat;
    } vec8_t;

    typedef struct {
        logic [15:0] din;
        logic [7:0]  res;
        logic [1:0]  flg;
        int          lat;
    } vec16_t;

    vec8_t  v8[12];
    vec16_t v16[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic start8(input logic [7:0] d, output int lat, output logic busy_ok);
        @(negedge clk);
        i8.in_data  = d;
        i8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        i8.in_valid = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!i8.out_valid && lat < 40) begin
            if (i8.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (i8.in_ready) busy_ok = 1'b0;
    endtask

    task automatic pop8();
        @(negedge clk);
        i8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        i8.out_ready = 1'b0;
    endtask

    task automatic start16(input logic [15:0] d, output int lat);
        @(negedge clk);
        i16.in_data  = d;
        i16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        i16.in_valid = 1'b0;
        lat = 0;
        while (!i16.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop16();
        @(negedge clk);
        i16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        i16.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic seen;

        checks = 0;
        errors = 0;

        v8[0]  = '{8'h01, 8'h38, 2'b00, 9};
        v8[1]  = '{8'h09, 8'h51, 2'b00, 6};
        v8[2]  = '{8'h13, 8'h5A, 2'b01, 5};
        v8[3]  = '{8'h11, 8'h58, 2'b01, 5};
        v8[4]  = '{8'h7F, 8'h70, 2'b01, 3};
        v8[5]  = '{8'h80, 8'hF0, 2'b00, 2};
        v8[6]  = '{8'h00, 8'h00, 2'b00, 2};
        v8[7]  = '{8'hFF, 8'hB8, 2'b00, 9};
        v8[8]  = '{8'hED, 8'hDA, 2'b01, 5};
        v8[9]  = '{8'h64, 8'h6C, 2'b01, 3};
        v8[10] = '{8'h81, 8'hF0, 2'b01, 3};
        v8[11] = '{8'h17, 8'h5C, 2'b01, 5};

        v16[0] = '{16'h7FFF, 8'h78, 2'b11, 3};
        v16[1] = '{16'h8000, 8'hF8, 2'b10, 2};
        v16[2] = '{16'h00FF, 8'h78, 2'b11, 10};
        v16[3] = '{16'h00F0, 8'h77, 2'b00, 10};
        v16[4] = '{16'h0001, 8'h38, 2'b00, 17};

        i8.in_data    = '0;
        i8.in_valid   = 1'b0;
        i8.out_ready  = 1'b0;
        i16.in_data   = '0;
        i16.in_valid  = 1'b0;
        i16.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready",  32'(i8.in_ready),  32'd1);
        check("reset_out_valid", 32'(i8.out_valid), 32'd0);
        check("reset_result",    32'(i8.result),    32'h0);
        check("reset_flags",     32'(i8.flags),     32'h0);

        for (int i = 0; i < 12; i++) begin
            start8(v8[i].din, lat, busy_ok);
            check($sformatf("res8[%0d]", i),  32'(i8.result), 32'(v8[i].res));
            check($sformatf("flg8[%0d]", i),  32'(i8.flags),  32'(v8[i].flg));
            check($sformatf("lat8[%0d]", i),  32'(lat),       32'(v8[i].lat));
            check($sformatf("busy8[%0d]", i), 32'(busy_ok),   32'd1);
            pop8();
            check($sformatf("idle_rdy8[%0d]", i), 32'(i8.in_ready),  32'd1);
            check($sformatf("idle_vld8[%0d]", i), 32'(i8.out_valid), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            start16(v16[i].din, lat);
            check($sformatf("res16[%0d]", i), 32'(i16.result), 32'(v16[i].res));
            check($sformatf("flg16[%0d]", i), 32'(i16.flags),  32'(v16[i].flg));
            check($sformatf("lat16[%0d]", i), 32'(lat),        32'(v16[i].lat));
            pop16();
        end

        // Backpressure: result must hold and in_valid must be ignored in DONE.
        start8(8'h13, lat, busy_ok);
        check("bp_first_res", 32'(i8.result), 32'h5A);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i8.in_data  = 8'h55;
            i8.in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp_res[%0d]", k),   32'(i8.result),    32'h5A);
            check($sformatf("bp_flg[%0d]", k),   32'(i8.flags),     32'h1);
            check($sformatf("bp_vld[%0d]", k),   32'(i8.out_valid), 32'd1);
            check($sformatf("bp_rdy[%0d]", k),   32'(i8.in_ready),  32'd0);
        end
        @(negedge clk);
        i8.in_valid = 1'b0;
        pop8();
        check("bp_release_rdy", 32'(i8.in_ready),  32'd1);
        check("bp_release_vld", 32'(i8.out_valid), 32'd0);

        // Reset while normalising a long-latency operand.
        @(negedge clk);
        i8.in_data  = 8'h01;
        i8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        i8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrst_vld", 32'(i8.out_valid), 32'd0);
        check("midrst_rdy", 32'(i8.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (i8.out_valid) seen = 1'b1;
        end
        check("midrst_no_stale", 32'(seen),        32'd0);
        check("midrst_rdy_after", 32'(i8.in_ready), 32'd1);

        start8(8'h09, lat, busy_ok);
        check("recover_res", 32'(i8.result), 32'h51);
        check("recover_lat", 32'(lat),       32'd6);
        pop8();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_to_minifloat.md
Name: int_to_minifloat

Overview:
- Serial converter feeding the float ALU: takes a signed two's-complement integer and produces the team's minifloat encoding (sign, exponent, mantissa; default 1/4/3 bits, bias 2^(EXP_W-1)-1).
- Normalises one bit position per cycle, then rounds to nearest, ties to even.
- Results go to the ALU a/b operand registers over a valid/ready handshake.

Parameters:
INT_W, 8, width of the signed integer input
EXP_W, 4, minifloat exponent field width
MANTISSA_W, 3, minifloat stored mantissa width (hidden 1 not stored)
WIDTH, 1+EXP_W+MANTISSA_W, minifloat word width (derived; not overridden independently)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  INT_W  signed integer operand
in_valid  input  1  in_data is valid
in_ready  output  1  converter can accept (high only in IDLE)
result  output  WIDTH  minifloat result {sign, exp, mantissa}
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
flags  output  2  {overflow, inexact}; valid while out_valid

Behaviour:
- Reset (async, rst_n low): state IDLE; result=0, flags=0, out_valid=0; in_ready=1 once reset deasserts. Reset mid-conversion aborts it with no output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch sign=in_data[INT_W-1], mag=|in_data| as INT_W-bit unsigned (-2^(INT_W-1) gives magnitude 2^(INT_W-1); no overflow), lz=0. Go to NORM.
  - NORM: if mag!=0 and mag[INT_W-1]==0, shift mag left 1 and increment lz. Otherwise go to ROUND. Zero spends 0 cycles here.
  - ROUND (one cycle): compute and register result/flags, go to DONE.
  - DONE: out_valid=1. result and flags held stable. On out_ready, go to IDLE (out_valid drops next cycle). in_ready stays 0 in DONE; no same-cycle accept.
- Latency: out_valid rises lz+2 clock edges after the accept edge. lz counts leading zeros of the INT_W-bit magnitude. Range: 2 (zero or MSB set) to INT_W+1 (magnitude 1).
- Arithmetic:
  - Unbiased exponent e = INT_W-1-lz. Biased eb = e+BIAS, computed at EXP_W+2 bits.
  - Mantissa m = mag[INT_W-2 -: MANTISSA_W]. Guard g = next lower bit. Sticky s = OR of all remaining lower bits (0 if none).
  - RNE round-up when g & (s | m[0]). On mantissa carry-out: m=0, eb+1.
  - inexact = g | s.
  - If eb >= 2^EXP_W-1, result = {sign, all-ones exp, 0} (infinity) and overflow=1.
- Zero input: result 0x00 (never -0), flags 0.
- Subnormal and NaN outputs are never produced.
- Handshake: while out_valid && !out_ready, result and flags must not change. in_valid is ignored outside IDLE.

Decomposition:
- Package minifloat_pkg:
  - EXP_W, MANTISSA_W, WIDTH, BIAS localparams
  - typedef struct packed {sign; exp[EXP_W]; mant[MANTISSA_W]} minifloat_t
  - EXP_MAX (all ones), INF_POS / INF_NEG constants
  - state enum {IDLE, NORM, ROUND, DONE}
  - flag bit indices
- Sub-module minifloat_round: combinational; normalised magnitude + lz + sign -> minifloat_t + flags. Reused later by the ALU's own normalise/round path.

Test Plan:
- in_data=1 -> result 0x38, flags 00, out_valid rises 9 edges after accept.
- in_data=9 -> 0x51 exact. in_data=19 -> 0x5A, inexact=1 (round up). in_data=17 -> 0x58, inexact=1 (tie to even, no round-up).
- in_data=127 -> 0x70, inexact=1 (mantissa carry bumps exponent). in_data=-128 (0x80) -> 0xF0, flags 00, latency 2.
- in_data=0 -> 0x00, flags 00, latency 2. Check in_ready=0 from accept until the cycle after the DONE handshake.
- INT_W=16 build: in_data=32767 -> 0x78, overflow=1, inexact=1. in_data=-32768 -> 0xF8, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_valid ignored. Then pulse rst_n low mid-NORM -> out_valid=0 and in_ready=1 after release, no stale result emitted.
